// File: rtl/gf_inv_itoh_tsujii.sv
// gf_inv_itoh_tsujii: GF(2^16) inverter, Itoh-Tsujii chain 1,1,3,3,6,1 with a bit-serial multiplier
module gf_inv_itoh_tsujii #(
  parameter int M = 16,
  parameter logic [M-1:0] POLY = 16'h002D
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [M-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [M-1:0] out_data_o,
  output logic         busy_o
);
  typedef enum logic [2:0] {IDLE, EXP, MUL, FINAL, DONE} state_t;
  state_t state_q, state_d;
  logic [M-1:0] acc_q, acc_d, b1_q, b1_d, b3_q, b3_d, b6_q, b6_d;
  logic [M-1:0] t_q, t_d, p_q, p_d, out_q, out_d;
  logic [3:0] j_q, j_d;
  logic [2:0] step_q, step_d;
  logic [M-1:0] f1, f3, f6, s, p_nxt;
  function automatic logic [M-1:0] gf_sq(input logic [M-1:0] x);
    logic [2*M-2:0] w;
    w = '0;
    for (int i = 0; i < M; i++) w[2*i] = x[i];
    for (int i = 2*M-2; i >= M; i--)
      if (w[i]) begin
        w[i] = 1'b0;
        w[i-M +: M] = w[i-M +: M] ^ POLY;
      end
    return w[M-1:0];
  endfunction
  // Squaring is linear, so these chains collapse to fixed XOR matrices.
  assign f1 = gf_sq(acc_q);
  assign f3 = gf_sq(gf_sq(f1));
  assign f6 = gf_sq(gf_sq(gf_sq(f3)));
  assign s = step_q < 3'd2 ? b1_q : step_q < 3'd4 ? b3_q : b6_q;
  assign p_nxt = {p_q[M-2:0], 1'b0} ^ (p_q[M-1] ? POLY : '0) ^ (s[4'(M-1) - j_q] ? t_q : '0);
  assign in_ready_o = state_q == IDLE;
  assign out_valid_o = state_q == DONE;
  assign busy_o = state_q != IDLE;
  assign out_data_o = out_q;
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    b1_d = b1_q;
    b3_d = b3_q;
    b6_d = b6_q;
    t_d = t_q;
    p_d = p_q;
    out_d = out_q;
    j_d = j_q;
    step_d = step_q;
    case (state_q)
      IDLE: if (in_valid_i) begin
        b1_d = in_data_i;
        acc_d = in_data_i;
        step_d = '0;
        state_d = EXP;
      end
      EXP: begin
        t_d = step_q < 3'd2 ? f1 : step_q < 3'd4 ? f3 : f6;
        p_d = '0;
        j_d = '0;
        state_d = MUL;
      end
      MUL: begin
        p_d = p_nxt;
        j_d = j_q + 4'd1;
        if (j_q == 4'd15) begin
          acc_d = p_nxt;
          b3_d = step_q == 3'd1 ? p_nxt : b3_q;
          b6_d = step_q == 3'd2 ? p_nxt : b6_q;
          step_d = step_q == 3'd4 ? step_q : step_q + 3'd1;
          state_d = step_q == 3'd4 ? FINAL : EXP;
        end
      end
      FINAL: begin
        out_d = f1;
        state_d = DONE;
      end
      DONE: state_d = out_ready_i ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      acc_q <= '0;
      b1_q <= '0;
      b3_q <= '0;
      b6_q <= '0;
      t_q <= '0;
      p_q <= '0;
      out_q <= '0;
      j_q <= '0;
      step_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      b1_q <= b1_d;
      b3_q <= b3_d;
      b6_q <= b6_d;
      t_q <= t_d;
      p_q <= p_d;
      out_q <= out_d;
      j_q <= j_d;
      step_q <= step_d;
    end
  end
endmodule
